// File: rtl/operand_stack.sv
// Operand stack feeding the ALU: tos/nos present the two newest entries.
// One command per clock; failing commands only raise the sticky flags.
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       cmd,
    input  logic [WIDTH-1:0] push_data,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] CMD_PUSH   = 3'd1;
    localparam logic [2:0] CMD_POP    = 3'd2;
    localparam logic [2:0] CMD_REDUCE = 3'd3;
    localparam logic [2:0] CMD_DUP    = 3'd4;
    localparam logic [2:0] CMD_SWAP   = 3'd5;
    localparam logic [2:0] CMD_CLEAR  = 3'd6;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry 0 is the oldest; the newest live entry sits at cnt-1.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cm1;
    logic [CW-1:0]    cm2;
    logic [AW-1:0]    widx;
    logic [AW-1:0]    tidx;
    logic [AW-1:0]    nidx;
    logic             is_empty;
    logic             is_full;
    logic             has_two;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] next_val;

    logic             wr_a_en;
    logic [AW-1:0]    wr_a_idx;
    logic [WIDTH-1:0] wr_a_data;
    logic             wr_b_en;
    logic [AW-1:0]    wr_b_idx;
    logic [WIDTH-1:0] wr_b_data;
    logic             set_ovf;
    logic             set_unf;
    logic             clr;

    assign cm1      = cnt - ONE;
    assign cm2      = cnt - TWO;
    assign widx     = cnt[AW-1:0];
    assign tidx     = cm1[AW-1:0];
    assign nidx     = cm2[AW-1:0];
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);
    assign has_two  = (cnt >= TWO);

    // Gate storage reads by count so stale entries never reach the ALU.
    assign top_val  = is_empty ? '0 : mem[tidx];
    assign next_val = has_two  ? mem[nidx] : '0;

    assign tos   = top_val;
    assign nos   = next_val;
    assign count = cnt;
    assign empty = is_empty;
    assign full  = is_full;

    // Command decode: storage writes, next count and flag updates.
    always_comb begin
        wr_a_en   = 1'b0;
        wr_a_idx  = widx;
        wr_a_data = push_data;
        wr_b_en   = 1'b0;
        wr_b_idx  = nidx;
        wr_b_data = top_val;
        cnt_nxt   = cnt;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        clr       = 1'b0;
        case (cmd)
            CMD_PUSH: begin
                if (is_full) begin
                    set_ovf = 1'b1;
                end else begin
                    wr_a_en = 1'b1;
                    cnt_nxt = cnt + ONE;
                end
            end
            CMD_POP: begin
                if (is_empty) set_unf = 1'b1;
                else          cnt_nxt = cnt - ONE;
            end
            CMD_REDUCE: begin
                if (!has_two) begin
                    set_unf = 1'b1;
                end else begin
                    wr_a_en   = 1'b1;
                    wr_a_idx  = nidx;
                    wr_a_data = alu_result;
                    cnt_nxt   = cnt - ONE;
                end
            end
            CMD_DUP: begin
                if (is_empty) begin
                    set_unf = 1'b1;
                end else if (is_full) begin
                    set_ovf = 1'b1;
                end else begin
                    wr_a_en   = 1'b1;
                    wr_a_data = top_val;
                    cnt_nxt   = cnt + ONE;
                end
            end
            CMD_SWAP: begin
                if (!has_two) begin
                    set_unf = 1'b1;
                end else begin
                    wr_a_en   = 1'b1;
                    wr_a_idx  = tidx;
                    wr_a_data = next_val;
                    wr_b_en   = 1'b1;
                end
            end
            CMD_CLEAR: begin
                clr     = 1'b1;
                cnt_nxt = '0;
            end
            default: ;
        endcase
    end

    // Storage needs no reset: everything above count is masked on read.
    always_ff @(posedge clk) begin
        if (wr_a_en) mem[wr_a_idx] <= wr_a_data;
        if (wr_b_en) mem[wr_b_idx] <= wr_b_data;
    end

    // Entry count; reset empties the stack without waiting for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_nxt;
    end

    // Sticky error flags, cleared only by CLEAR or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (set_ovf) ovf <= 1'b1;
            if (set_unf) unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack against a queue-based model.
// Directed scenarios followed by a randomized command stream.
module tb_operand_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic [2:0]       cmd;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    int n_checks;
    int n_fail;

    // model: queue back is the top of stack
    logic [WIDTH-1:0] q[$];
    logic             m_ovf;
    logic             m_unf;

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd),
        .push_data(push_data),
        .alu_result(alu_result),
        .tos(tos),
        .nos(nos),
        .count(count),
        .empty(empty),
        .full(full),
        .ovf(ovf),
        .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_apply(input logic [2:0] c,
                                        input logic [WIDTH-1:0] pd,
                                        input logic [WIDTH-1:0] ar);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int n;
        n = q.size();
        case (c)
            3'd1: if (n < DEPTH) q.push_back(pd); else m_ovf = 1'b1;
            3'd2: if (n >= 1) void'(q.pop_back()); else m_unf = 1'b1;
            3'd3: begin
                if (n >= 2) begin
                    void'(q.pop_back());
                    void'(q.pop_back());
                    q.push_back(ar);
                end else m_unf = 1'b1;
            end
            3'd4: begin
                if (n == 0) m_unf = 1'b1;
                else if (n == DEPTH) m_ovf = 1'b1;
                else q.push_back(q[n-1]);
            end
            3'd5: begin
                if (n >= 2) begin
                    a = q[n-1];
                    b = q[n-2];
                    q[n-1] = b;
                    q[n-2] = a;
                end else m_unf = 1'b1;
            end
            3'd6: begin
                q.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [CW+4+2*WIDTH-1:0] model_vec();
        int n;
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] s;
        n = q.size();
        t = (n >= 1) ? q[n-1] : '0;
        s = (n >= 2) ? q[n-2] : '0;
        return {CW'(n), (n == 0), (n == DEPTH), m_ovf, m_unf, t, s};
    endfunction

    wire [CW+4+2*WIDTH-1:0] obs = {count, empty, full, ovf, unf, tos, nos};

    task automatic step(input logic [2:0] c,
                        input logic [WIDTH-1:0] pd,
                        input logic [WIDTH-1:0] ar);
        cmd = c;
        push_data = pd;
        alu_result = ar;
        @(posedge clk);
        model_apply(c, pd, ar);
        #1;
        cmd = 3'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd = 3'd0;
        push_data = '0;
        alu_result = '0;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state got %h expected all-zero/empty", obs);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reduce();
        step(3'd1, 8'h05, 8'h00);
        step(3'd1, 8'h03, 8'h00);
        n_checks++;
        if ({count, nos, tos} !== {4'd2, 8'h05, 8'h03}) begin
            n_fail++;
            $display("FAIL push_two got cnt=%0d nos=%h tos=%h req 2/05/03",
                     count, nos, tos);
        end
        step(3'd3, 8'h00, 8'h02);
        n_checks++;
        if ({count, tos, nos} !== {4'd1, 8'h02, 8'h00}) begin
            n_fail++;
            $display("FAIL reduce got cnt=%0d tos=%h nos=%h req 1/02/00",
                     count, tos, nos);
        end
    endtask

    task automatic test_overflow();
        step(3'd6, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(3'd1, 8'(8'h11 + i), 8'h00);
        n_checks++;
        if ({full, count, tos, nos, ovf} !== {1'b1, 4'd8, 8'h18, 8'h17, 1'b0}) begin
            n_fail++;
            $display("FAIL fill got full=%b cnt=%0d tos=%h nos=%h ovf=%b req 1/8/18/17/0",
                     full, count, tos, nos, ovf);
        end
        step(3'd1, 8'h99, 8'h00);
        n_checks++;
        if ({ovf, count, tos, unf} !== {1'b1, 4'd8, 8'h18, 1'b0}) begin
            n_fail++;
            $display("FAIL overflow got ovf=%b cnt=%0d tos=%h unf=%b req 1/8/18/0",
                     ovf, count, tos, unf);
        end
        step(3'd4, 8'h00, 8'h00);
        n_checks++;
        if ({count, tos, nos} !== {4'd8, 8'h18, 8'h17}) begin
            n_fail++;
            $display("FAIL dup_full got cnt=%0d tos=%h nos=%h req 8/18/17",
                     count, tos, nos);
        end
    endtask

    task automatic test_underflow();
        step(3'd6, 8'h00, 8'h00);
        step(3'd2, 8'h00, 8'h00);
        n_checks++;
        if ({unf, count, tos, ovf} !== {1'b1, 4'd0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL pop_empty got unf=%b cnt=%0d tos=%h ovf=%b req 1/0/00/0",
                     unf, count, tos, ovf);
        end
        step(3'd1, 8'h01, 8'h00);
        step(3'd3, 8'h00, 8'h77);
        n_checks++;
        if ({unf, count, tos, nos} !== {1'b1, 4'd1, 8'h01, 8'h00}) begin
            n_fail++;
            $display("FAIL reduce_one got unf=%b cnt=%0d tos=%h nos=%h req 1/1/01/00",
                     unf, count, tos, nos);
        end
        step(3'd5, 8'h00, 8'h00);
        n_checks++;
        if ({count, tos} !== {4'd1, 8'h01}) begin
            n_fail++;
            $display("FAIL swap_one got cnt=%0d tos=%h req 1/01", count, tos);
        end
    endtask

    task automatic test_dup_swap();
        step(3'd6, 8'h00, 8'h00);
        step(3'd1, 8'hAA, 8'h00);
        step(3'd4, 8'h00, 8'h00);
        n_checks++;
        if ({count, tos, nos} !== {4'd2, 8'hAA, 8'hAA}) begin
            n_fail++;
            $display("FAIL dup got cnt=%0d tos=%h nos=%h req 2/AA/AA",
                     count, tos, nos);
        end
        step(3'd1, 8'h55, 8'h00);
        step(3'd5, 8'h00, 8'h00);
        n_checks++;
        if ({count, tos, nos, unf} !== {4'd3, 8'hAA, 8'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL swap got cnt=%0d tos=%h nos=%h unf=%b req 3/AA/55/0",
                     count, tos, nos, unf);
        end
        step(3'd2, 8'h00, 8'h00);
        n_checks++;
        if ({count, tos, nos} !== {4'd2, 8'h55, 8'hAA}) begin
            n_fail++;
            $display("FAIL pop got cnt=%0d tos=%h nos=%h req 2/55/AA",
                     count, tos, nos);
        end
    endtask

    task automatic test_clear();
        step(3'd6, 8'h00, 8'h00);
        step(3'd2, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH + 1; i++) step(3'd1, 8'(8'h40 + i), 8'h00);
        for (int i = 0; i < 3; i++) step(3'd2, 8'h00, 8'h00);
        n_checks++;
        if ({count, ovf, unf} !== {4'd5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_clear got cnt=%0d ovf=%b unf=%b req 5/1/1",
                     count, ovf, unf);
        end
        step(3'd6, 8'h00, 8'h00);
        n_checks++;
        if (obs !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL clear got %h required empty/flags-clear", obs);
        end
    endtask

    task automatic test_async_reset();
        step(3'd6, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) step(3'd1, 8'(8'hC0 + i), 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL async_reset got %h required reset values", obs);
        end
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        step(3'd1, 8'h3C, 8'h00);
        n_checks++;
        if ({count, tos, nos} !== {4'd1, 8'h3C, 8'h00}) begin
            n_fail++;
            $display("FAIL post_reset_push got cnt=%0d tos=%h nos=%h req 1/3C/00",
                     count, tos, nos);
        end
    endtask

    task automatic test_random();
        logic [2:0] c;
        logic [WIDTH-1:0] pd;
        logic [WIDTH-1:0] ar;
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      c = 3'd1;
            else if (r < 55) c = 3'd2;
            else if (r < 68) c = 3'd3;
            else if (r < 78) c = 3'd4;
            else if (r < 88) c = 3'd5;
            else if (r < 91) c = 3'd6;
            else if (r < 96) c = 3'd0;
            else             c = 3'd7;
            pd = 8'($urandom);
            ar = 8'($urandom);
            step(c, pd, ar);
            n_checks++;
            if (obs !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d] cmd=%0d got %h expected %h",
                         i, c, obs, model_vec());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b1;
        test_reset();
        test_reduce();
        test_overflow();
        test_underflow();
        test_dup_swap();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
# operand_stack

Operand stack for the stack-machine datapath, sitting directly upstream of the ALU. Holds up to DEPTH words and presents the two topmost entries as the ALU operands. Executes one stack command per clock: push, pop, ALU reduce (replace top two with the ALU result), dup, swap and clear. Overflow and underflow are flagged and the offending command is suppressed.

## Interface
- WIDTH, 8, data word width; must equal the ALU operand width.
- DEPTH, 8, maximum number of entries; legal range 2..16.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- cmd  input  3  stack command: 0 NOP, 1 PUSH, 2 POP, 3 REDUCE, 4 DUP, 5 SWAP, 6 CLEAR, 7 NOP (reserved).
- push_data  input  WIDTH  word written by PUSH.
- alu_result  input  WIDTH  ALU output, written by REDUCE.
- tos  output  WIDTH  top of stack; drives ALU in_b.
- nos  output  WIDTH  next of stack; drives ALU in_a.
- count  output  $clog2(DEPTH+1)  current number of entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky overflow flag.
- unf  output  1  sticky underflow flag.

## Operation
- Operand order: nos is the older entry, tos the newer; for "a b SUB" the ALU computes a - b with in_a = nos, in_b = tos.
- tos = 0 when count == 0; nos = 0 when count < 2. Never expose stale storage.
- PUSH: count < DEPTH -> push_data becomes tos, old tos becomes nos, count+1. count == DEPTH -> no change, ovf set.
- POP: count >= 1 -> top removed, count-1, nos moves to tos. count == 0 -> no change, unf set.
- REDUCE: count >= 2 -> top two removed, alu_result pushed, count-1. count < 2 -> no change, unf set.
- DUP: 1 <= count < DEPTH -> copy of tos pushed, count+1. count == 0 -> unf set; count == DEPTH -> ovf set; no change in either case.
- SWAP: count >= 2 -> tos and nos exchanged, count unchanged. count < 2 -> no change, unf set.
- CLEAR: count -> 0, ovf and unf -> 0, regardless of prior state.
- NOP / 7: no change.
- ovf/unf stay set until CLEAR or reset; a failing command never alters count or contents.
- Entries below nos are not observable; their contents after POP/CLEAR are don't-care but must not leak to tos/nos.
- Sole state element: stack storage plus pointer/count and two flag registers; no internal FSM beyond the count.

## Timing
- Reset (rst_n low, asynchronous): count = 0, empty = 1, full = 0, tos = 0, nos = 0, ovf = 0, unf = 0. Release is synchronised by the surrounding design; block behaves normally from the first edge with rst_n high.
- Reset mid-sequence discards all entries immediately, without waiting for a clock edge.
- cmd, push_data, alu_result sampled on rising edge k; tos, nos, count, empty, full, flags reflect the result after edge k (latency 1, no bubbles, one command accepted every cycle).
- tos/nos are functions of registered state only; no combinational path from cmd, push_data or alu_result to any output. The REDUCE loop (tos/nos -> ALU -> alu_result -> stack) is therefore single-cycle and registered at this block.
- Back-to-back commands in consecutive cycles fully supported, including PUSH at count == DEPTH-1 followed by PUSH (second sets ovf).

## Test plan
- Reset then PUSH 0x05, PUSH 0x03 -> count 2, nos 0x05, tos 0x03; REDUCE with alu_result 0x02 -> count 1, tos 0x02, nos 0x00.
- PUSH 0x11..0x18 (DEPTH 8) -> full 1, tos 0x18, nos 0x17; 9th PUSH 0x99 -> ovf 1, count 8, tos 0x18 unchanged.
- From empty: POP -> unf 1, count 0, tos 0; then PUSH 0x01, REDUCE -> unf still 1, count 1, tos 0x01.
- PUSH 0xAA, DUP -> count 2, tos 0xAA, nos 0xAA; PUSH 0x55, SWAP -> tos 0xAA, nos 0x55, count 3.
- With ovf and unf both set and count 5: CLEAR -> count 0, empty 1, ovf 0, unf 0, tos 0, nos 0.
- Assert rst_n low between clock edges with count 4 -> all outputs return to reset values before the next edge; first command after release operates on an empty stack.
